cv32e40p_aligner_tmr: RTL and testbench
=======================================

Name: cv32e40p_aligner_tmr

Overview:
- Instruction aligner that sits directly upstream of the triplicated compressed decoder, between the prefetch buffer and the decoder input.
- Takes word-aligned 32-bit fetch words and emits one instruction per handshake, either 16-bit or 32-bit, word-aligned or misaligned, together with its PC.
- All state is triple-modular-redundant: FSM state, upper-halfword buffer and PC each have three copies, read through a bitwise majority vote, with per-group mismatch flags.

Parameters:
- PC_RESET, 32'h0000_0000, value of the PC copies after reset.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- fetch_valid_i  input  1  fetch_rdata_i holds a valid word
- fetch_rdata_i  input  32  word-aligned fetch data
- fetch_ready_o  output  1  current fetch word is consumed this cycle (combinational)
- if_valid_i  input  1  IF stage accepts the presented instruction
- branch_i  input  1  redirect request
- branch_addr_i  input  32  redirect target; bit 0 is ignored
- instr_aligned_o  output  32  aligned instruction; bits [31:16] are don't-care for 16-bit instructions
- instr_valid_o  output  1  instr_aligned_o is valid
- pc_o  output  32  PC of the presented instruction (voted)
- error_voter_o  output  3  registered mismatch flags: [0] state, [1] halfword buffer, [2] PC

Behaviour:
- Reset (async, rst_n=0):
  - All state copies = ALIGNED32; all halfword copies = 16'h0; all PC copies = PC_RESET.
  - error_voter_o = 3'b000.
  - Combinational outputs follow from the reset state.
- Compressed test: an instruction is 16-bit iff its lowest two bits != 2'b11.
- consume = instr_valid_o & if_valid_i.
- States: ALIGNED32, MISALIGNED, BRANCH_MISALIGNED.
- ALIGNED32:
  - instr_aligned_o = fetch_rdata_i; instr_valid_o = fetch_valid_i.
  - On consume of a 32-bit instruction: PC += 4; fetch_ready_o = 1; stay.
  - On consume of a 16-bit instruction: PC += 2; buffer <= fetch_rdata_i[31:16]; fetch_ready_o = 1; go to MISALIGNED.
- MISALIGNED, buffer holds a 16-bit instruction:
  - instr_aligned_o = {fetch_rdata_i[15:0], buffer}; instr_valid_o = 1, independent of fetch_valid_i.
  - fetch_ready_o = 0.
  - On consume: PC += 2; go to ALIGNED32.
- MISALIGNED, buffer holds the lower half of a 32-bit instruction:
  - instr_aligned_o = {fetch_rdata_i[15:0], buffer}; instr_valid_o = fetch_valid_i.
  - On consume: PC += 4; buffer <= fetch_rdata_i[31:16]; fetch_ready_o = 1; stay.
- BRANCH_MISALIGNED (the lower half of the first word is discarded):
  - Upper half is 16-bit: instr_aligned_o = {16'h0, fetch_rdata_i[31:16]}; instr_valid_o = fetch_valid_i. On consume: PC += 2; fetch_ready_o = 1; go to ALIGNED32.
  - Upper half is 32-bit: instr_valid_o = 0. When fetch_valid_i = 1: buffer <= fetch_rdata_i[31:16]; fetch_ready_o = 1; go to MISALIGNED. PC is unchanged.
- Branch priority: branch_i overrides every state in the same cycle.
  - PC <= {branch_addr_i[31:1], 1'b0}.
  - Next state = BRANCH_MISALIGNED if branch_addr_i[1] = 1, else ALIGNED32.
  - instr_valid_o = 0 and fetch_ready_o = 0 in the branch cycle; a coincident if_valid_i is ignored.
- Wrap-around: PC arithmetic is modulo 2^32 (32'hFFFF_FFFE + 2 = 32'h0).
- TMR voting:
  - Every read of state, buffer and PC uses the bitwise 2-of-3 majority of the three copies.
  - On any update, all three copies are written with the same next value computed from the voted values.
  - A single corrupted copy therefore never affects outputs and is repaired by the next update.
- error_voter_o[k] is registered: set in the cycle after any copy of group k disagrees with the others, cleared when they agree. No latency is added to the datapath.
- A state copy vote producing the unused encoding is treated as ALIGNED32.
- Latency: zero cycles, fetch word to instr_aligned_o. The only bubble is the BRANCH_MISALIGNED 32-bit case, which costs one extra fetch word.
- Reset mid-operation: immediate return to the reset values; the buffered halfword is lost.

Optional Feature:
- Macro: CV32E40P_ALIGNER_SCRUB_EN.
- Defined: on every cycle without an update, all three copies of each group are rewritten with their voted value. A single upset is corrected within one cycle, and error_voter_o pulses for exactly one cycle.
- Undefined: copies are written only on updates. A corrupted copy persists, and error_voter_o stays high, until the next update of that group.

Test Plan:
- Sequential 32-bit instructions: words 32'h0000_0513, 32'h0010_0593 with if_valid_i = 1 -> two valid outputs, pc_o 0 then 4, fetch_ready_o = 1 each cycle.
- Mixed halves: word 32'h4585_4501 (two C.LI) -> outputs 16'h4501 at PC 0 and 16'h4585 at PC 2. fetch_ready_o = 1 only in the first cycle; the second output is valid with fetch_valid_i = 0.
- Spanning 32-bit instruction: words 32'h0513_4501 then 32'hxxxx_0000 -> second output 32'h0000_0513 at PC 2, then state stays MISALIGNED.
- Branch to 32'h0000_0102, first word 32'h0593_xxxx then 32'h....0010 -> one bubble, then instr_aligned_o = 32'h0010_0593 with pc_o = 32'h102. A branch asserted together with consume -> PC takes the branch target, not PC + 4.
- Fault injection: force PC copy 1 to 32'hDEAD_BEEF for one cycle -> pc_o unchanged, error_voter_o[2] = 1 the next cycle. With scrubbing enabled the flag clears after one cycle; without it, the flag clears after the next consume.
- Assert rst_n low while in MISALIGNED with buffer 16'h4585 -> state ALIGNED32, pc_o = PC_RESET, error_voter_o = 0 asynchronously.

Source files
------------

// File: rtl/cv32e40p_aligner_tmr_if.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_aligner_tmr_if
// Description : Fetch-side / decode-side handshake bundle of the TMR
//               instruction aligner.
//                 fetch_valid_i   : fetch_rdata_i holds a valid word
//                 fetch_rdata_i   : word-aligned 32-bit fetch data
//                 fetch_ready_o   : current fetch word consumed this cycle
//                 if_valid_i      : IF stage accepts the presented instruction
//                 branch_i        : redirect request
//                 branch_addr_i   : redirect target (bit 0 ignored)
//                 instr_aligned_o : aligned instruction
//                 instr_valid_o   : instr_aligned_o is valid
//                 pc_o            : PC of the presented instruction
//               master = environment (prefetch buffer + IF stage),
//               slave  = aligner.
// Revision    : 1.0 - initial release
// ============================================================================
interface cv32e40p_aligner_tmr_if;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        if_valid_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic [31:0] instr_aligned_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;

  modport master (
    output fetch_valid_i, fetch_rdata_i, if_valid_i, branch_i, branch_addr_i,
    input  fetch_ready_o, instr_aligned_o, instr_valid_o, pc_o
  );

  modport slave (
    input  fetch_valid_i, fetch_rdata_i, if_valid_i, branch_i, branch_addr_i,
    output fetch_ready_o, instr_aligned_o, instr_valid_o, pc_o
  );
endinterface
`default_nettype wire

// File: rtl/cv32e40p_aligner_tmr.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_aligner_tmr
// Description : Instruction aligner with triple-modular-redundant state.
//               Turns word-aligned fetch words into one 16- or 32-bit
//               instruction per handshake plus its PC. FSM state, the
//               buffered upper halfword and the PC each exist three times
//               and are read through a bitwise 2-of-3 majority vote.
// Ports       : clk, rst_n (async, active low)
//               bus           : cv32e40p_aligner_tmr_if.slave handshake
//               error_voter_o : registered copy-mismatch flags
//                               [0] state, [1] halfword buffer, [2] PC
// Options     : CV32E40P_ALIGNER_SCRUB_EN - when defined, every copy of
//               every group is rewritten with its voted value on each cycle
//               without an update, so a single upset lives one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_aligner_tmr #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  wire                           clk,
  input  wire                           rst_n,
  cv32e40p_aligner_tmr_if.slave         bus,
  output logic [2:0]                    error_voter_o
);

  typedef enum logic [1:0] {
    ALIGNED32         = 2'b00,
    MISALIGNED        = 2'b01,
    BRANCH_MISALIGNED = 2'b10
  } state_e;

  // next-value for all copies of each group
  logic [1:0]  state_d;
  logic [15:0] hword_d;
  logic [31:0] pc_d;
  logic        wr_state, wr_hword, wr_pc;

  // triplicated storage
  for (genvar i = 0; i < 3; i++) begin : g_copy
    logic [1:0]  state_q;
    logic [15:0] hword_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ALIGNED32;
        hword_q <= 16'h0000;
        pc_q    <= PC_RESET;
      end else begin
        if (wr_state) state_q <= state_d;
        if (wr_hword) hword_q <= hword_d;
        if (wr_pc)    pc_q    <= pc_d;
      end
    end
  end

  // majority voters
  logic [1:0]  state_vote;
  logic [15:0] hword_v;
  logic [31:0] pc_v;
  state_e      state_v;

  assign state_vote = (g_copy[0].state_q & g_copy[1].state_q) |
                      (g_copy[0].state_q & g_copy[2].state_q) |
                      (g_copy[1].state_q & g_copy[2].state_q);
  assign hword_v    = (g_copy[0].hword_q & g_copy[1].hword_q) |
                      (g_copy[0].hword_q & g_copy[2].hword_q) |
                      (g_copy[1].hword_q & g_copy[2].hword_q);
  assign pc_v       = (g_copy[0].pc_q & g_copy[1].pc_q) |
                      (g_copy[0].pc_q & g_copy[2].pc_q) |
                      (g_copy[1].pc_q & g_copy[2].pc_q);

  // the unused encoding 2'b11 decodes as ALIGNED32
  always_comb begin
    case (state_vote)
      2'b01:   state_v = MISALIGNED;
      2'b10:   state_v = BRANCH_MISALIGNED;
      default: state_v = ALIGNED32;
    endcase
  end

  // datapath / next-state
  logic [15:0] upper;
  logic        lower_is_c, upper_is_c, hword_is_c;
  logic [31:0] instr;
  logic        valid, ready, consume;
  state_e      state_n;
  logic [15:0] hword_n;
  logic [31:0] pc_n;
  logic        state_we, hword_we, pc_we;

  assign upper      = bus.fetch_rdata_i[31:16];
  assign lower_is_c = (bus.fetch_rdata_i[1:0] != 2'b11);
  assign upper_is_c = (bus.fetch_rdata_i[17:16] != 2'b11);
  assign hword_is_c = (hword_v[1:0] != 2'b11);

  always_comb begin
    instr    = bus.fetch_rdata_i;
    valid    = 1'b0;
    ready    = 1'b0;
    consume  = 1'b0;
    state_n  = state_v;
    hword_n  = hword_v;
    pc_n     = pc_v;
    state_we = 1'b0;
    hword_we = 1'b0;
    pc_we    = 1'b0;

    case (state_v)
      MISALIGNED: begin
        instr = {bus.fetch_rdata_i[15:0], hword_v};
        if (hword_is_c) begin
          // the buffered instruction is complete; no fetch word needed
          valid   = 1'b1;
          consume = bus.if_valid_i;
          if (consume) begin
            pc_n     = pc_v + 32'd2;
            state_n  = ALIGNED32;
            pc_we    = 1'b1;
            state_we = 1'b1;
          end
        end else begin
          valid   = bus.fetch_valid_i;
          consume = valid & bus.if_valid_i;
          if (consume) begin
            pc_n     = pc_v + 32'd4;
            hword_n  = upper;
            ready    = 1'b1;
            pc_we    = 1'b1;
            hword_we = 1'b1;
            state_we = 1'b1;
          end
        end
      end

      BRANCH_MISALIGNED: begin
        instr = {16'h0000, upper};
        if (upper_is_c) begin
          valid   = bus.fetch_valid_i;
          consume = valid & bus.if_valid_i;
          if (consume) begin
            pc_n     = pc_v + 32'd2;
            state_n  = ALIGNED32;
            ready    = 1'b1;
            pc_we    = 1'b1;
            state_we = 1'b1;
          end
        end else if (bus.fetch_valid_i) begin
          // first half of a spanning instruction: bubble, PC stays
          hword_n  = upper;
          state_n  = MISALIGNED;
          ready    = 1'b1;
          hword_we = 1'b1;
          state_we = 1'b1;
        end
      end

      default: begin
        valid   = bus.fetch_valid_i;
        consume = valid & bus.if_valid_i;
        if (consume) begin
          ready    = 1'b1;
          pc_we    = 1'b1;
          state_we = 1'b1;
          if (lower_is_c) begin
            pc_n     = pc_v + 32'd2;
            hword_n  = upper;
            state_n  = MISALIGNED;
            hword_we = 1'b1;
          end else begin
            pc_n = pc_v + 32'd4;
          end
        end
      end
    endcase

    // a redirect wins over everything decided above
    if (bus.branch_i) begin
      valid    = 1'b0;
      ready    = 1'b0;
      consume  = 1'b0;
      pc_n     = {bus.branch_addr_i[31:1], 1'b0};
      state_n  = bus.branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED32;
      hword_n  = hword_v;
      pc_we    = 1'b1;
      state_we = 1'b1;
      hword_we = 1'b0;
    end
  end

  // copy write values: the update value, or the voted value for a scrub
  always_comb begin
    state_d = state_we ? state_n : state_v;
    hword_d = hword_we ? hword_n : hword_v;
    pc_d    = pc_we    ? pc_n    : pc_v;
  end

`ifdef CV32E40P_ALIGNER_SCRUB_EN
  assign wr_state = 1'b1;
  assign wr_hword = 1'b1;
  assign wr_pc    = 1'b1;
`else
  assign wr_state = state_we;
  assign wr_hword = hword_we;
  assign wr_pc    = pc_we;
`endif

  // copy-mismatch detection, one register stage
  logic [2:0] error_voter_d;
  logic [2:0] error_voter_q;

  always_comb begin
    error_voter_d    = 3'b000;
    error_voter_d[0] = (g_copy[0].state_q != g_copy[1].state_q) ||
                       (g_copy[1].state_q != g_copy[2].state_q);
    error_voter_d[1] = (g_copy[0].hword_q != g_copy[1].hword_q) ||
                       (g_copy[1].hword_q != g_copy[2].hword_q);
    error_voter_d[2] = (g_copy[0].pc_q != g_copy[1].pc_q) ||
                       (g_copy[1].pc_q != g_copy[2].pc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) error_voter_q <= 3'b000;
    else        error_voter_q <= error_voter_d;
  end

  // bit 0 of the redirect target has no meaning for a halfword PC
  logic unused_branch_addr0;
  assign unused_branch_addr0 = bus.branch_addr_i[0];

  assign bus.instr_aligned_o = instr;
  assign bus.instr_valid_o   = valid;
  assign bus.fetch_ready_o   = ready;
  assign bus.pc_o            = pc_v;
  assign error_voter_o       = error_voter_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_aligner_tmr.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_aligner_tmr
// Description : Self-checking bench for cv32e40p_aligner_tmr. Directed
//               scenarios followed by random programs whose expected
//               instruction stream is derived from a halfword memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_aligner_tmr;

  logic       clk;
  logic       rst_n;
  logic [2:0] error_voter;

  cv32e40p_aligner_tmr_if bus();

  cv32e40p_aligner_tmr #(.PC_RESET(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .error_voter_o (error_voter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] rd, input logic ifv,
                       input logic br, input logic [31:0] ba);
    bus.fetch_valid_i = fv;
    bus.fetch_rdata_i = rd;
    bus.if_valid_i    = ifv;
    bus.branch_i      = br;
    bus.branch_addr_i = ba;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_pc",    bus.pc_o, 32'h0);
    chk("rst_valid", {31'h0, bus.instr_valid_o}, 32'h0);
    chk("rst_ready", {31'h0, bus.fetch_ready_o}, 32'h0);
    chk("rst_err",   {29'h0, error_voter}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // reference program image for the random phase
  logic [15:0] hw [0:255];
  logic [31:0] exp_pc  [0:63];
  logic [31:0] exp_ins [0:63];
  logic        exp_c   [0:63];

  initial begin
    logic [31:0] a, pc, w;
    logic [15:0] h;
    int          p, n, idx, fptr, cyc;

    rst_n = 1'b0;
    idle();
    #12;

    // ---- sequential 32-bit instructions ----
    do_reset();
    drive(1'b1, 32'h0000_0513, 1'b1, 1'b0, 32'h0); #1;
    chk("seq0_valid", {31'h0, bus.instr_valid_o}, 32'h1);
    chk("seq0_instr", bus.instr_aligned_o, 32'h0000_0513);
    chk("seq0_pc",    bus.pc_o, 32'h0);
    chk("seq0_ready", {31'h0, bus.fetch_ready_o}, 32'h1);
    @(negedge clk);
    drive(1'b1, 32'h0010_0593, 1'b1, 1'b0, 32'h0); #1;
    chk("seq1_instr", bus.instr_aligned_o, 32'h0010_0593);
    chk("seq1_pc",    bus.pc_o, 32'h4);
    chk("seq1_ready", {31'h0, bus.fetch_ready_o}, 32'h1);
    @(negedge clk); idle(); #1;
    chk("seq_pc_end", bus.pc_o, 32'h8);

    // ---- two compressed in one word ----
    do_reset();
    drive(1'b1, 32'h4585_4501, 1'b1, 1'b0, 32'h0); #1;
    chk("mix0_instr", {16'h0, bus.instr_aligned_o[15:0]}, 32'h4501);
    chk("mix0_pc",    bus.pc_o, 32'h0);
    chk("mix0_ready", {31'h0, bus.fetch_ready_o}, 32'h1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); #1;
    chk("mix1_valid", {31'h0, bus.instr_valid_o}, 32'h1);
    chk("mix1_instr", {16'h0, bus.instr_aligned_o[15:0]}, 32'h4585);
    chk("mix1_pc",    bus.pc_o, 32'h2);
    chk("mix1_ready", {31'h0, bus.fetch_ready_o}, 32'h0);
    @(negedge clk); idle(); #1;
    chk("mix_end_pc",    bus.pc_o, 32'h4);
    chk("mix_end_valid", {31'h0, bus.instr_valid_o}, 32'h0);

    // ---- instruction spanning two words ----
    do_reset();
    drive(1'b1, 32'h0513_4501, 1'b1, 1'b0, 32'h0); #1;
    chk("span0_instr", {16'h0, bus.instr_aligned_o[15:0]}, 32'h4501);
    @(negedge clk);
    drive(1'b1, 32'hABCD_0000, 1'b1, 1'b0, 32'h0); #1;
    chk("span1_valid", {31'h0, bus.instr_valid_o}, 32'h1);
    chk("span1_instr", bus.instr_aligned_o, 32'h0000_0513);
    chk("span1_pc",    bus.pc_o, 32'h2);
    chk("span1_ready", {31'h0, bus.fetch_ready_o}, 32'h1);
    @(negedge clk);
    drive(1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h0); #1;
    // still misaligned: buffered 16'hABCD is compressed, valid without fetch
    chk("span2_valid", {31'h0, bus.instr_valid_o}, 32'h1);
    chk("span2_instr", {16'h0, bus.instr_aligned_o[15:0]}, 32'hABCD);
    chk("span2_pc",    bus.pc_o, 32'h6);

    // ---- branch to a misaligned target ----
    do_reset();
    drive(1'b1, 32'h0000_0513, 1'b1, 1'b1, 32'h0000_0102); #1;
    chk("br_valid", {31'h0, bus.instr_valid_o}, 32'h0);
    chk("br_ready", {31'h0, bus.fetch_ready_o}, 32'h0);
    @(negedge clk);
    drive(1'b1, 32'h0593_1111, 1'b1, 1'b0, 32'h0); #1;
    chk("bub_valid", {31'h0, bus.instr_valid_o}, 32'h0);
    chk("bub_ready", {31'h0, bus.fetch_ready_o}, 32'h1);
    chk("bub_pc",    bus.pc_o, 32'h102);
    @(negedge clk);
    drive(1'b1, 32'h1234_0010, 1'b1, 1'b0, 32'h0); #1;
    chk("brm_valid", {31'h0, bus.instr_valid_o}, 32'h1);
    chk("brm_instr", bus.instr_aligned_o, 32'h0010_0593);
    chk("brm_pc",    bus.pc_o, 32'h102);
    @(negedge clk); idle(); #1;
    chk("brm_pc_end", bus.pc_o, 32'h106);

    // ---- branch coinciding with a consume ----
    do_reset();
    drive(1'b1, 32'h0000_0513, 1'b1, 1'b1, 32'h0000_0200); #1;
    chk("brc_valid", {31'h0, bus.instr_valid_o}, 32'h0);
    @(negedge clk); idle(); #1;
    chk("brc_pc", bus.pc_o, 32'h200);

    // ---- PC wrap-around, bit 0 of the target ignored ----
    do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(1'b1, 32'h4501_0000, 1'b1, 1'b0, 32'h0); #1;
    chk("wrap_valid", {31'h0, bus.instr_valid_o}, 32'h1);
    chk("wrap_instr", {16'h0, bus.instr_aligned_o[15:0]}, 32'h4501);
    chk("wrap_pc",    bus.pc_o, 32'hFFFF_FFFE);
    chk("wrap_ready", {31'h0, bus.fetch_ready_o}, 32'h1);
    @(negedge clk); idle(); #1;
    chk("wrap_pc_end", bus.pc_o, 32'h0);
    chk("wrap_valid_end", {31'h0, bus.instr_valid_o}, 32'h0);

    // ---- fault injection on PC copy 1 ----
    do_reset();
    @(negedge clk);
    force dut.g_copy[1].pc_q = 32'hDEAD_BEEF;
    #1;
    chk("fi_pc0", bus.pc_o, 32'h0);
    @(negedge clk); #1;
    chk("fi_err1", {29'h0, error_voter}, 32'h4);
    chk("fi_pc1",  bus.pc_o, 32'h0);
    @(negedge clk); #1;
    chk("fi_err2", {29'h0, error_voter}, 32'h4);
    release dut.g_copy[1].pc_q;
    drive(1'b1, 32'h0000_0513, 1'b1, 1'b0, 32'h0);
    @(negedge clk); idle();
    @(negedge clk); #1;
    chk("fi_err_clr", {29'h0, error_voter}, 32'h0);
    chk("fi_pc_end",  bus.pc_o, 32'h4);

    // ---- asynchronous reset while misaligned ----
    do_reset();
    drive(1'b1, 32'h4585_4501, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    idle(); #1;
    chk("ar_pre_valid", {31'h0, bus.instr_valid_o}, 32'h1);
    chk("ar_pre_instr", {16'h0, bus.instr_aligned_o[15:0]}, 32'h4585);
    rst_n = 1'b0; #1;
    chk("ar_valid", {31'h0, bus.instr_valid_o}, 32'h0);
    chk("ar_pc",    bus.pc_o, 32'h0);
    chk("ar_err",   {29'h0, error_voter}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- random programs against the memory-image model ----
    for (int r = 0; r < 4; r++) begin
      a = ($urandom & 32'hFFFF_F000) | ((r % 2 == 1) ? 32'h2 : 32'h0);
      for (int k = 0; k < 256; k++) hw[k] = 16'($urandom);
      n  = 40;
      p  = a[1] ? 1 : 0;
      pc = a;
      for (int i = 0; i < n; i++) begin
        exp_pc[i] = pc;
        if ($urandom_range(0, 1) == 1) begin
          h = 16'($urandom);
          if (h[1:0] == 2'b11) h[1:0] = 2'b01;
          hw[p]      = h;
          exp_ins[i] = {16'h0, h};
          exp_c[i]   = 1'b1;
          p  += 1;
          pc += 32'd2;
        end else begin
          w = $urandom;
          w[1:0] = 2'b11;
          hw[p]      = w[15:0];
          hw[p + 1]  = w[31:16];
          exp_ins[i] = w;
          exp_c[i]   = 1'b0;
          p  += 2;
          pc += 32'd4;
        end
      end

      @(negedge clk);
      drive(1'b0, $urandom, 1'b0, 1'b1, a | 32'($urandom_range(0, 1)));
      @(negedge clk);
      idx  = 0;
      fptr = 0;
      cyc  = 0;
      while (idx < n && cyc < 2000) begin
        bus.branch_i      = 1'b0;
        bus.fetch_valid_i = ($urandom_range(0, 3) != 0);
        bus.if_valid_i    = ($urandom_range(0, 3) != 0);
        bus.fetch_rdata_i = bus.fetch_valid_i ? {hw[2*fptr+1], hw[2*fptr]} : $urandom;
        #1;
        if (bus.instr_valid_o && bus.if_valid_i) begin
          chk("rnd_pc", bus.pc_o, exp_pc[idx]);
          if (exp_c[idx])
            chk("rnd_instr16", {16'h0, bus.instr_aligned_o[15:0]}, exp_ins[idx]);
          else
            chk("rnd_instr32", bus.instr_aligned_o, exp_ins[idx]);
          idx++;
        end
        if (bus.fetch_valid_i && bus.fetch_ready_o) fptr++;
        @(negedge clk);
        cyc++;
      end
      idle();
      chk("rnd_done", 32'(idx), 32'(n));
      chk("rnd_err",  {29'h0, error_voter}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
